// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master with a programmable SCLK divider, all four CPOL/CPHA modes and selectable bit order.
// Valid/ready: start is honoured only while busy is low; done pulses once per word with dout valid.
module spi_master_cfg #(
    parameter int DATA_W    = 12,
    parameter int CLK_DIV   = 10,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DATA_W-1:0] din,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout,
    output logic [2:0]        o_dbg_state
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [DIV_W-1:0]   r_div;
    logic [EDGE_W-1:0]  r_edge;
    logic [DATA_W-1:0]  r_tx;
    logic [DATA_W-1:0]  r_rx;
    logic [DATA_W-1:0]  r_dout;
    logic               r_cpol;
    logic               r_cpha;
    logic               r_sclk;
    logic               r_mosi;
    logic               r_cs_n;
    logic               r_busy;
    logic               r_done;

    logic               w_tick;
    logic               w_last_edge;
    logic               w_leading;
    logic               w_sample;
    logic               w_drive;
    logic               w_din_bit;
    logic               w_tx_bit;
    logic [DATA_W-1:0]  w_din_shift;
    logic [DATA_W-1:0]  w_tx_shift;
    logic [DATA_W-1:0]  w_rx_shift;

    assign w_tick      = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_last_edge = (r_edge == EDGE_W'(2 * DATA_W - 1));
    // Even edge indices move SCLK away from CPOL, i.e. they are leading edges.
    assign w_leading   = ~r_edge[0];
    assign w_sample    = (r_state == S_XFER) && w_tick && (w_leading ^ r_cpha);
    assign w_drive     = (r_state == S_XFER) && w_tick && !(w_leading ^ r_cpha) && !w_last_edge;

    assign w_din_bit   = MSB_FIRST ? din[DATA_W-1] : din[0];
    assign w_din_shift = MSB_FIRST ? {din[DATA_W-2:0], 1'b0} : {1'b0, din[DATA_W-1:1]};
    assign w_tx_bit    = MSB_FIRST ? r_tx[DATA_W-1] : r_tx[0];
    assign w_tx_shift  = MSB_FIRST ? {r_tx[DATA_W-2:0], 1'b0} : {1'b0, r_tx[DATA_W-1:1]};
    assign w_rx_shift  = MSB_FIRST ? {r_rx[DATA_W-2:0], miso} : {miso, r_rx[DATA_W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)                 w_next = S_SETUP;
            S_SETUP: if (w_tick)                w_next = S_XFER;
            S_XFER:  if (w_tick && w_last_edge) w_next = S_HOLD;
            S_HOLD:  if (w_tick)                w_next = S_GAP;
            S_GAP:   if (w_tick)                w_next = S_IDLE;
            default:                            w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_edge <= '0;
            r_tx   <= '0;
            r_rx   <= '0;
            r_dout <= '0;
            r_cpol <= 1'b0;
            r_cpha <= 1'b0;
            r_sclk <= 1'b0;
            r_mosi <= 1'b0;
            r_cs_n <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) r_div <= '0;
            else                   r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            case (r_state)
                S_IDLE: begin
                    r_sclk <= r_cpol;
                    if (start) begin
                        r_cpol <= cpol;
                        r_cpha <= cpha;
                        r_sclk <= cpol;
                        r_cs_n <= 1'b0;
                        r_busy <= 1'b1;
                        r_rx   <= '0;
                        r_edge <= '0;
                        // CPHA=0 slaves sample on the first edge, so bit 0 must be on the wire already.
                        if (cpha) begin
                            r_tx   <= din;
                            r_mosi <= 1'b0;
                        end else begin
                            r_tx   <= w_din_shift;
                            r_mosi <= w_din_bit;
                        end
                    end
                end
                S_XFER: begin
                    if (w_tick) begin
                        r_sclk <= ~r_sclk;
                        r_edge <= w_last_edge ? '0 : r_edge + EDGE_W'(1);
                        if (w_sample) r_rx <= w_rx_shift;
                        if (w_drive) begin
                            r_mosi <= w_tx_bit;
                            r_tx   <= w_tx_shift;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_tick) begin
                        r_cs_n <= 1'b1;
                        r_mosi <= 1'b0;
                        r_dout <= r_rx;
                        r_done <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_tick) r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign sclk        = r_sclk;
    assign mosi        = r_mosi;
    assign cs_n        = r_cs_n;
    assign busy        = r_busy;
    assign done        = r_done;
    assign dout        = r_dout;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: three parameter sets, each driven against a behavioural SPI slave
// that knows only the mode, word width and bit order of the transfer.
module tb_spi_master_cfg;
    localparam int DW_V  [3] = '{8, 12, 8};
    localparam int DIV_V [3] = '{4, 3, 1};
    localparam bit MSB_V [3] = '{1'b1, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_v [3] = '{1'b0, 1'b0, 1'b0};
    logic        cpol_v  [3] = '{1'b0, 1'b0, 1'b0};
    logic        cpha_v  [3] = '{1'b0, 1'b0, 1'b0};
    logic        loop_v  [3] = '{1'b0, 1'b0, 1'b0};
    logic        miso_v  [3] = '{1'b0, 1'b0, 1'b0};
    logic [11:0] din_w   [3] = '{12'h0, 12'h0, 12'h0};
    wire         sclk_v  [3];
    wire         mosi_v  [3];
    wire         cs_n_v  [3];
    wire         busy_v  [3];
    wire         done_v  [3];
    wire         miso_in [3];
    wire [2:0]   st_v    [3];
    wire [7:0]   dout_a;
    wire [11:0]  dout_b;
    wire [7:0]   dout_c;

    assign miso_in[0] = loop_v[0] ? mosi_v[0] : miso_v[0];
    assign miso_in[1] = loop_v[1] ? mosi_v[1] : miso_v[1];
    assign miso_in[2] = loop_v[2] ? mosi_v[2] : miso_v[2];

    spi_master_cfg #(.DATA_W(DW_V[0]), .CLK_DIV(DIV_V[0]), .MSB_FIRST(MSB_V[0])) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .cpol(cpol_v[0]), .cpha(cpha_v[0]),
        .din(din_w[0][7:0]), .miso(miso_in[0]), .sclk(sclk_v[0]), .mosi(mosi_v[0]),
        .cs_n(cs_n_v[0]), .busy(busy_v[0]), .done(done_v[0]), .dout(dout_a), .o_dbg_state(st_v[0]));
    spi_master_cfg #(.DATA_W(DW_V[1]), .CLK_DIV(DIV_V[1]), .MSB_FIRST(MSB_V[1])) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .cpol(cpol_v[1]), .cpha(cpha_v[1]),
        .din(din_w[1]), .miso(miso_in[1]), .sclk(sclk_v[1]), .mosi(mosi_v[1]),
        .cs_n(cs_n_v[1]), .busy(busy_v[1]), .done(done_v[1]), .dout(dout_b), .o_dbg_state(st_v[1]));
    spi_master_cfg #(.DATA_W(DW_V[2]), .CLK_DIV(DIV_V[2]), .MSB_FIRST(MSB_V[2])) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .cpol(cpol_v[2]), .cpha(cpha_v[2]),
        .din(din_w[2][7:0]), .miso(miso_in[2]), .sclk(sclk_v[2]), .mosi(mosi_v[2]),
        .cs_n(cs_n_v[2]), .busy(busy_v[2]), .done(done_v[2]), .dout(dout_c), .o_dbg_state(st_v[2]));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] get_dout(input int k);
        case (k)
            0:       return {4'h0, dout_a};
            1:       return dout_b;
            default: return {4'h0, dout_c};
        endcase
    endfunction

    function automatic int bidx(input int k, input int i);
        return MSB_V[k] ? DW_V[k] - 1 - i : i;
    endfunction

    function automatic logic [11:0] wmask(input int k);
        return 12'hFFF >> (12 - DW_V[k]);
    endfunction

    // Behavioural slave: samples MOSI and shifts MISO on the edges its mode dictates.
    logic [11:0] stx   [3] = '{12'h0, 12'h0, 12'h0};
    logic [11:0] cap   [3] = '{12'h0, 12'h0, 12'h0};
    logic        mcpol [3] = '{1'b0, 1'b0, 1'b0};
    logic        mcpha [3] = '{1'b0, 1'b0, 1'b0};
    logic        prev_cs   [3] = '{1'b1, 1'b1, 1'b1};
    logic        prev_sclk [3] = '{1'b0, 1'b0, 1'b0};
    int          edges [3] = '{0, 0, 0};
    int          rxi   [3] = '{0, 0, 0};
    int          txi   [3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (cs_n_v[k]) begin
                prev_cs[k] = 1'b1;
            end else if (prev_cs[k]) begin
                prev_cs[k] = 1'b0;
                edges[k] = 0; rxi[k] = 0; txi[k] = 0; cap[k] = '0;
                prev_sclk[k] = sclk_v[k];
                if (!mcpha[k]) begin
                    miso_v[k] <= stx[k][bidx(k, 0)];
                    txi[k] = 1;
                end
            end else if (sclk_v[k] !== prev_sclk[k]) begin
                prev_sclk[k] = sclk_v[k];
                edges[k]++;
                if ((sclk_v[k] != mcpol[k]) ^ mcpha[k]) begin
                    if (rxi[k] < DW_V[k]) cap[k][bidx(k, rxi[k])] = mosi_v[k];
                    rxi[k]++;
                end else if (txi[k] < DW_V[k]) begin
                    miso_v[k] <= stx[k][bidx(k, txi[k])];
                    txi[k]++;
                end
            end
        end
    end

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (busy_v[k] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", busy_v[k], 1'b0);
    endtask

    task automatic xfer(input int k, input logic p, input logic h, input logic [11:0] d,
                        input logic [11:0] sw, input logic lb, input int rst_at);
        int n, tt, dv, tog;
        logic ps;
        logic [11:0] dm, exp_rx;
        dv = DIV_V[k];
        tt = (2 * DW_V[k] + 2) * dv;
        dm = d & wmask(k);
        exp_rx = lb ? dm : (sw & wmask(k));
        mcpol[k] = p; mcpha[k] = h; stx[k] = sw & wmask(k); loop_v[k] = lb;
        @(negedge clk);
        wait_idle(k);
        start_v[k] = 1'b1; din_w[k] = dm; cpol_v[k] = p; cpha_v[k] = h;
        @(negedge clk);
        start_v[k] = 1'b0;
        chk("accept_cs_n", cs_n_v[k], 1'b0);
        chk("accept_busy", busy_v[k], 1'b1);
        chk("setup_sclk", sclk_v[k], p);
        if (!h) chk("setup_mosi", mosi_v[k], dm[bidx(k, 0)]);
        din_w[k] = 12'($urandom); cpol_v[k] = ~p; cpha_v[k] = ~h;
        n = 1; tog = 0; ps = p;
        while (!done_v[k] && n < tt + 50) begin
            @(negedge clk);
            n++;
            if (sclk_v[k] !== ps) begin
                tog++;
                ps = sclk_v[k];
            end
            if (rst_at > 0 && tog == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_cs_n", cs_n_v[k], 1'b1);
                chk("rst_sclk", sclk_v[k], 1'b0);
                chk("rst_busy", busy_v[k], 1'b0);
                repeat (3) @(negedge clk);
                chk("rst_no_done", done_v[k], 1'b0);
                rst_n = 1'b1;
                return;
            end
        end
        chk("done_seen", done_v[k], 1'b1);
        chk("done_latency", n - 1, tt);
        chk("dout", get_dout(k), exp_rx);
        chk("slave_rx", cap[k], dm);
        chk("sclk_edges", edges[k], 2 * DW_V[k]);
        chk("end_cs_n", cs_n_v[k], 1'b1);
        chk("end_sclk", sclk_v[k], p);
        chk("end_mosi", mosi_v[k], 1'b0);
        for (int m = 1; m <= dv; m++) begin
            @(negedge clk);
            if (m == 1) chk("done_width", done_v[k], 1'b0);
            if (m == dv - 1) chk("gap_busy", busy_v[k], 1'b1);
            if (m == dv) chk("gap_end_busy", busy_v[k], 1'b0);
        end
    endtask

    task automatic back_to_back(input int k, input logic [11:0] d, input logic [11:0] sw);
        int n, dones, falls, run, minrun, last_done, spacing;
        logic pcs;
        mcpol[k] = 1'b0; mcpha[k] = 1'b0; stx[k] = sw & wmask(k); loop_v[k] = 1'b0;
        @(negedge clk);
        wait_idle(k);
        start_v[k] = 1'b1; din_w[k] = d & wmask(k); cpol_v[k] = 1'b0; cpha_v[k] = 1'b0;
        n = 0; dones = 0; falls = 0; run = 0; minrun = 100000; last_done = -1; spacing = 0;
        pcs = 1'b1;
        while (dones < 3 && n < 2000) begin
            @(negedge clk);
            n++;
            if (pcs && !cs_n_v[k]) begin
                falls++;
                if (falls > 1 && run < minrun) minrun = run;
            end
            if (cs_n_v[k]) run++;
            else run = 0;
            pcs = cs_n_v[k];
            if (done_v[k]) begin
                dones++;
                if (last_done >= 0) spacing = n - last_done;
                last_done = n;
            end
        end
        start_v[k] = 1'b0;
        chk("b2b_dones", dones, 3);
        chk("b2b_accepts", falls, 3);
        chk("b2b_cs_high", minrun, DIV_V[k] + 1);
        chk("b2b_spacing", spacing, (2 * DW_V[k] + 3) * DIV_V[k] + 1);
        chk("b2b_dout", get_dout(k), sw & wmask(k));
        chk("b2b_slave_rx", cap[k], d & wmask(k));
        repeat (DIV_V[k] + 8) @(negedge clk);
        chk("b2b_stopped", cs_n_v[k], 1'b1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_pins", {27'h0, sclk_v[k], mosi_v[k], cs_n_v[k], busy_v[k], done_v[k]}, 32'b00100);
            chk("reset_dout", get_dout(k), 12'h0);
            chk("reset_state", st_v[k], 3'd0);
        end
        rst_n = 1'b1;
        xfer(0, 1'b0, 1'b0, 12'h0A5, 12'h000, 1'b1, 0);
        xfer(0, 1'b1, 1'b1, 12'h03C, 12'h0C3, 1'b0, 0);
        xfer(1, 1'b0, 1'b1, 12'h801, 12'h000, 1'b1, 0);
        xfer(2, 1'b1, 1'b0, 12'h0FF, 12'h000, 1'b1, 0);
        back_to_back(0, 12'h05A, 12'h0E7);
        xfer(0, 1'b0, 1'b0, 12'h0C9, 12'h036, 1'b0, 5);
        xfer(0, 1'b0, 1'b0, 12'h0C9, 12'h036, 1'b0, 0);
        for (int i = 0; i < 30; i++) begin
            xfer($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 12'($urandom), 12'($urandom), 1'($urandom_range(0, 1)), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
